// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle adder/subtractor that processes CHUNK bits per clock
//
// Adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per cycle,
// least-significant slice first, carrying between slices in a register.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request a new operation (accepted in IDLE or DONE, ignored in RUN)
//   a, b  - operands (WIDTH bits), captured on the accepting edge
//   cin   - carry-in (add) / borrow-in (subtract)
//   sub   - 0 = add, 1 = subtract
//   busy  - high while slices are being processed
//   done  - one-cycle completion pulse
//   s     - result, held between completions
//   cout  - carry-out; in subtract mode 1 means no borrow
//   ovf   - signed two's-complement overflow
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Operands are stored post-inversion so the RUN datapath is always a plain add.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;

  logic             accept;
  logic             last_step;
  logic [31:0]      off;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] acc_d;

  // Start is honoured in IDLE and DONE only, which gives back-to-back
  // operations from the done cycle while leaving a running op untouched.
  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_step = (state_q == RUN) && (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = start ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Slice datapath
  // ---------------------------------------------------------------------
  assign off  = 32'(idx_q) * 32'(CHUNK);
  assign a_sl = CHUNK'(a_q >> off);
  assign b_sl = CHUNK'(b_q >> off);

  assign slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK+1)'(carry_q);

  // Merge the current slice into the partial result; on the last slice this
  // is the complete result that gets published to s.
  assign acc_d = (acc_q & ~(SLICE_MASK << off))
               | (WIDTH'(slice_sum[CHUNK-1:0]) << off);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      // Subtract uses a + ~b + ~cin, so the borrow-in is inverted here.
      carry_q <= cin ^ sub;
      acc_q   <= '0;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      acc_q   <= acc_d;
      carry_q <= slice_sum[CHUNK];
      idx_q   <= last_step ? '0 : idx_q + IDXW'(1);
      if (last_step) begin
        s    <= acc_d;
        cout <= slice_sum[CHUNK];
        // Overflow: both effective operands share a sign that the result lacks.
        ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

endmodule
